fmul_sched: RTL and testbench

FMUL_SCHED -- requirements
Module: fmul_sched

---
 rtl/fmul_sched.sv | 178 +++++++++++++++++
 tb/tb_fmul_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_sched.sv
// fmul_sched: round-robin scheduler sharing one fixed-latency fmul
// between two requesters. Define FMUL_SCHED_PERF_EN for perf counters.
module fmul_sched #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic [31:0] fmul_x1,
  output logic [31:0] fmul_x2,
  input  logic [31:0] fmul_y,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_y,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_y
`ifdef FMUL_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [1:0]       req_v;
  logic [1:0]       rsp_rdy;
  logic [1:0]       elig;
  logic [1:0]       gnt;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       rsp_v;
  logic [1:0][31:0] op_x1;
  logic [1:0][31:0] op_x2;
  logic [1:0][31:0] rsp_y;
  logic             issue;
  logic             last_q;
  logic [LAT:1]     pv_q;
  logic [LAT:1]     pid_q;

  assign req_v   = {req1_valid, req0_valid};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign op_x1   = {req1_x1, req0_x1};
  assign op_x2   = {req1_x2, req0_x2};

  // on a tie the port not granted last wins
  assign gnt[0] = elig[0] & (~elig[1] | last_q);
  assign gnt[1] = elig[1] & (~elig[0] | ~last_q);
  assign issue  = |gnt;

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // steer the granted operands to the multiplier, zero when idle
  always_comb begin
    fmul_x1 = '0;
    fmul_x2 = '0;
    unique case (1'b1)
      gnt[0]: begin
        fmul_x1 = op_x1[0];
        fmul_x2 = op_x2[0];
      end
      gnt[1]: begin
        fmul_x1 = op_x1[1];
        fmul_x2 = op_x2[1];
      end
      default: ;
    endcase
  end

  // last-grant pointer moves only when an op issues
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else if (issue) begin
      last_q <= gnt[1];
    end
  end

  // issue valids travel alongside the multiplier pipeline
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pv_q <= '0;
    end else begin
      pv_q[1] <= issue;
      for (int i = 2; i <= LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
      end
    end
  end

  // port ids follow the valids; only meaningful where valid is set
  always_ff @(posedge clk) begin
    pid_q[1] <= gnt[1];
    for (int i = 2; i <= LAT; i++) begin
      pid_q[i] <= pid_q[i-1];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [31:0]   mem_q [DEPTH];
    logic [CW-1:0] wp_q;
    logic [CW-1:0] rp_q;
    logic [CW-1:0] cred_q;
    logic [CW-1:0] cred_d;

    assign elig[p]  = rstn & req_v[p] & (cred_q < CW'(DEPTH));
    assign rsp_v[p] = rstn & (wp_q != rp_q);
    assign rsp_y[p] = mem_q[rp_q[AW-1:0]];
    assign pop[p]   = rsp_v[p] & rsp_rdy[p];
    assign push[p]  = pv_q[LAT] & (pid_q[LAT] == 1'(p));

    // credit counts ops in flight plus FIFO occupancy
    always_comb begin
      cred_d = cred_q;
      unique case ({gnt[p], pop[p]})
        2'b10:   cred_d = cred_q + CW'(1);
        2'b01:   cred_d = cred_q - CW'(1);
        default: ;
      endcase
    end

    // FIFO pointers carry an extra wrap bit for full/empty
    always_ff @(posedge clk) begin
      if (!rstn) begin
        wp_q   <= '0;
        rp_q   <= '0;
        cred_q <= '0;
      end else begin
        if (push[p]) wp_q <= wp_q + CW'(1);
        if (pop[p])  rp_q <= rp_q + CW'(1);
        cred_q <= cred_d;
      end
    end

    // result storage, written when the tagged op leaves the fmul
    always_ff @(posedge clk) begin
      if (rstn && push[p]) begin
        mem_q[wp_q[AW-1:0]] <= fmul_y;
      end
    end
  end

  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign rsp0_y     = rsp_y[0];
  assign rsp1_y     = rsp_y[1];

`ifdef FMUL_SCHED_PERF_EN
  logic [31:0] piss_q;
  logic [31:0] pstl_q;

  // issue and stall counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      piss_q <= '0;
      pstl_q <= '0;
    end else begin
      if (issue) piss_q <= piss_q + 32'd1;
      if (|req_v && !issue) pstl_q <= pstl_q + 32'd1;
    end
  end

  assign perf_issue = piss_q;
  assign perf_stall = pstl_q;
`endif

endmodule

// File: tb/tb_fmul_sched.sv
// tb_fmul_sched: table vectors, directed corner sequences and random
// traffic against a queue-based model of the scheduler.
module tb_fmul_sched;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
  logic [31:0] fmul_x1, fmul_x2, fmul_y;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_y, rsp1_y;
`ifdef FMUL_SCHED_PERF_EN
  logic [31:0] perf_issue, perf_stall;
`endif

  fmul_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x1(req1_x1), .req1_x2(req1_x2),
    .fmul_x1(fmul_x1), .fmul_x2(fmul_x2), .fmul_y(fmul_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y)
`ifdef FMUL_SCHED_PERF_EN
    , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // simple normal-range float multiply (truncating), exact for the table
  function automatic logic [31:0] fmul_model(input logic [31:0] a,
                                             input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 10'd1;
    end else begin
      f = m[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  // external multiplier stand-in with latency LAT
  logic [63:0] hist [LAT];
  always @(posedge clk) begin
    hist[0] <= {fmul_x1, fmul_x2};
    for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
  end
  assign fmul_y = fmul_model(hist[LAT-1][63:32], hist[LAT-1][31:0]);

  typedef struct {
    logic [31:0] y;
    int          vis;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   out0, out1, last;
  int   cyc;
  int   checks, errors;
  bit   s_rdy0, s_rdy1, s_v0, s_v1;
  logic [31:0] s_y0, s_y1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_f();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(154, 100));
    return r;
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    out0 = 0;
    out1 = 0;
    last = 1;
  endtask

  // one clock cycle: drive, check against the model, advance the model
  task automatic step(input bit v0, input bit v1,
                      input bit r0, input bit r1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1);
    bit e0, e1, g0, g1, ev0, ev1;
    logic [31:0] ex1, ex2;
    req0_valid = v0; req1_valid = v1;
    req0_x1 = a0; req0_x2 = b0;
    req1_x1 = a1; req1_x2 = b1;
    rsp0_ready = r0; rsp1_ready = r1;
    @(negedge clk);
    e0 = v0 && (out0 < DEPTH);
    e1 = v1 && (out1 < DEPTH);
    g0 = e0 && (!e1 || last == 1);
    g1 = e1 && (!e0 || last == 0);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (q0.size() > 0) ev0 = (q0[0].vis <= cyc);
    if (q1.size() > 0) ev1 = (q1[0].vis <= cyc);
    ex1 = g0 ? a0 : (g1 ? a1 : 32'd0);
    ex2 = g0 ? b0 : (g1 ? b1 : 32'd0);
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    chk("fmul_x1", fmul_x1, ex1);
    chk("fmul_x2", fmul_x2, ex2);
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    if (ev0) chk("rsp0_y", rsp0_y, q0[0].y);
    if (ev1) chk("rsp1_y", rsp1_y, q1[0].y);
    s_rdy0 = req0_ready; s_rdy1 = req1_ready;
    s_v0 = rsp0_valid; s_v1 = rsp1_valid;
    s_y0 = rsp0_y; s_y1 = rsp1_y;
    if (ev0 && r0) begin
      void'(q0.pop_front());
      out0--;
    end
    if (ev1 && r1) begin
      void'(q1.pop_front());
      out1--;
    end
    if (g0) begin
      q0.push_back('{fmul_model(a0, b0), cyc + LAT + 1});
      out0++;
      last = 0;
    end
    if (g1) begin
      q1.push_back('{fmul_model(a1, b1), cyc + LAT + 1});
      out1++;
      last = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // one reset cycle with requests asserted; outputs must stay quiet
  task automatic do_reset();
    rstn = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x1 = 32'h3f800000; req0_x2 = 32'h3f800000;
    req1_x1 = 32'h40000000; req1_x2 = 32'h40000000;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_fmul_x1", fmul_x1, 32'd0);
    chk("rst_fmul_x2", fmul_x2, 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    rstn = 1'b1;
    model_clear();
  endtask

  typedef struct {
    bit          port;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n;
    bit p;
    checks = 0;
    errors = 0;
    cyc = 0;
    model_clear();
    rstn = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_x1 = 0; req0_x2 = 0; req1_x1 = 0; req1_x2 = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    tbl[0] = '{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000};
    tbl[1] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    tbl[2] = '{1'b0, 32'hC0000000, 32'h3F000000, 32'hBF800000};
    tbl[3] = '{1'b1, 32'h40800000, 32'h3E800000, 32'h3F800000};
    tbl[4] = '{1'b1, 32'h40400000, 32'h40400000, 32'h41100000};

    @(posedge clk);
    #1;
    do_reset();

    // single ops: latency LAT+1 and product value
    for (int i = 0; i < 5; i++) begin
      p = tbl[i].port;
      step(!p, p, 0, 0, tbl[i].x1, tbl[i].x2, tbl[i].x1, tbl[i].x2);
      chk("tbl_issue", 32'(p ? s_rdy1 : s_rdy0), 32'd1);
      idle(LAT);
      chk("tbl_early", 32'(p ? s_v1 : s_v0), 32'd0);
      step(0, 0, !p, p, 0, 0, 0, 0);
      chk("tbl_valid", 32'(p ? s_v1 : s_v0), 32'd1);
      chk("tbl_y", p ? s_y1 : s_y0, tbl[i].y);
      idle(1);
      chk("tbl_drain", 32'(p ? s_v1 : s_v0), 32'd0);
    end

    // contention: grants alternate starting with port 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 1, rnd_f(), rnd_f(), rnd_f(), rnd_f());
      chk("rr_g0", 32'(s_rdy0), 32'((i % 2) == 0));
      chk("rr_g1", 32'(s_rdy1), 32'((i % 2) == 1));
    end
    idle(LAT + 2);

    // backpressure on port 1: DEPTH issues, then one per pop
    do_reset();
    n = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      step(0, 1, 0, 0, 0, 0, rnd_f(), rnd_f());
      n += int'(s_rdy1);
    end
    chk("bp_issues", 32'(n), 32'(DEPTH));
    chk("bp_blocked", 32'(s_rdy1), 32'd0);
    step(0, 1, 0, 1, 0, 0, rnd_f(), rnd_f());
    chk("bp_pop", 32'(s_v1), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0, 0, rnd_f(), rnd_f());
      n += int'(s_rdy1);
    end
    chk("bp_one_more", 32'(n), 32'd1);

    // full credit, then pop and issue together each cycle
    do_reset();
    for (int i = 0; i < DEPTH + LAT + 1; i++)
      step(1, 0, 0, 0, rnd_f(), rnd_f(), 0, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, 0, rnd_f(), rnd_f(), 0, 0);
      n += int'(s_rdy0);
    end
    chk("sim_issues", 32'(n), 32'd5);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, rnd_f(), rnd_f(), 0, 0);
      n += int'(s_rdy0);
    end
    chk("sim_refill", 32'(n), 32'd1);

    // reset with two ops in flight
    do_reset();
    step(1, 1, 0, 0, rnd_f(), rnd_f(), rnd_f(), rnd_f());
    step(1, 1, 0, 0, rnd_f(), rnd_f(), rnd_f(), rnd_f());
    do_reset();
    idle(LAT + 3);
    chk("mid_rst_v0", 32'(s_v0), 32'd0);
    chk("mid_rst_v1", 32'(s_v1), 32'd0);
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1, 0, 0, 0, rnd_f(), rnd_f(), 0, 0);
      n += int'(s_rdy0);
    end
    chk("mid_rst_credit", 32'(n), 32'(DEPTH));

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           rnd_f(), rnd_f(), rnd_f(), rnd_f());
    end

`ifdef FMUL_SCHED_PERF_EN
    // 10 issues and 3 stalls
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++)
      step(0, 1, 0, 0, 0, 0, rnd_f(), rnd_f());
    for (int i = 0; i < 6; i++)
      step(1, 0, 1, 0, rnd_f(), rnd_f(), 0, 0);
    chk("perf_issue", perf_issue, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
